// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Bundles the write-back arbiter's request handshake, register-file
//            write port and scoreboard clear port into one interface.
// Ports    : req_valid/req_rd/req_data/wb_stall  - function-unit side (in)
//            req_ready                            - one-hot grant (out)
//            rf_we/rf_waddr/rf_wdata              - register-file write (out)
//            sb_clr/sb_clr_rd                     - scoreboard clear (out)
//            byp_valid/byp_rd/byp_data            - early forward (out, only
//                                                   with WB_BYPASS_EN)
// Modports : master - requesters/environment, slave - the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_stall;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 sb_clr;
  logic [4:0]           sb_clr_rd;
`ifdef WB_BYPASS_EN
  logic                 byp_valid;
  logic [4:0]           byp_rd;
  logic [XLEN-1:0]      byp_data;

  modport master (
    output req_valid, req_rd, req_data, wb_stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd,
    input  byp_valid, byp_rd, byp_data
  );
  modport slave (
    input  req_valid, req_rd, req_data, wb_stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd,
    output byp_valid, byp_rd, byp_data
  );
`else
  modport master (
    output req_valid, req_rd, req_data, wb_stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd
  );
  modport slave (
    input  req_valid, req_rd, req_data, wb_stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, sb_clr, sb_clr_rd
  );
`endif
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            among NREQ function units. One grant per cycle; the winning
//            result is registered toward the register file together with the
//            scoreboard pending-bit clear for its destination register.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            wb   - wb_arbiter_if.slave (requests, grants, rf/sb outputs)
// Options  : WB_BYPASS_EN - adds combinational byp_* forwarding of the
//            winning transfer in its grant cycle
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  wb_arbiter_if.slave wb
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_clr;
  logic [4:0]      r_clr_rd;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic            w_xfer;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic            w_nonzero;

  // Search req_valid starting at r_ptr, wrapping modulo NREQ; first hit wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && wb.req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  // Reset gating keeps req_ready low while rst is asserted.
  assign w_xfer    = w_found && !wb.wb_stall && !rst;
  assign w_rd      = wb.req_rd[int'(w_win)*5 +: 5];
  assign w_data    = wb.req_data[int'(w_win)*XLEN +: XLEN];
  assign w_nonzero = (w_rd != 5'd0);

  assign wb.req_ready = w_xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= 5'd0;
      r_wdata  <= '0;
      r_clr    <= 1'b0;
      r_clr_rd <= 5'd0;
    end else if (w_xfer) begin
      r_ptr    <= (int'(w_win) == NREQ-1) ? '0 : w_win + 1'b1;
      // x0 results are accepted and latched, but never write or clear.
      r_we     <= w_nonzero;
      r_clr    <= w_nonzero;
      r_waddr  <= w_rd;
      r_wdata  <= w_data;
      r_clr_rd <= w_rd;
    end else begin
      r_we     <= 1'b0;
      r_clr    <= 1'b0;
    end
  end

  assign wb.rf_we     = r_we;
  assign wb.rf_waddr  = r_waddr;
  assign wb.rf_wdata  = r_wdata;
  assign wb.sb_clr    = r_clr;
  assign wb.sb_clr_rd = r_clr_rd;

`ifdef WB_BYPASS_EN
  assign wb.byp_valid = w_xfer && w_nonzero;
  assign wb.byp_rd    = w_rd;
  assign wb.byp_data  = w_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (NREQ=3, XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) wb ();

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) u_dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [4:0] rd, input logic [31:0] data);
    wb.req_rd[u*5 +: 5]       = rd;
    wb.req_data[u*XLEN +: XLEN] = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    wb.req_valid = '0;
    wb.req_rd    = '0;
    wb.req_data  = '0;
    wb.wb_stall  = 1'b0;

    // Reset with unit 1 pending: no grant while in reset.
    set_unit(1, 5'd9, 32'h0000_0099);
    wb.req_valid = 3'b010;
    tick();
    tick();
    check("rst_ready", 64'(wb.req_ready), 64'h0);
    check("rst_we",    64'(wb.rf_we),     64'h0);
    check("rst_clr",   64'(wb.sb_clr),    64'h0);

    // Release: ptr=0, unit 0 idle, unit 1 wins.
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(wb.req_ready), 64'h2);
    tick();
    check("post_rst_we",    64'(wb.rf_we),     64'h1);
    check("post_rst_waddr", 64'(wb.rf_waddr),  64'd9);
    check("post_rst_clrrd", 64'(wb.sb_clr_rd), 64'd9);

    // Second grant to unit 1 (ptr=2 wraps to 1), then async reset mid-cycle.
    check("wrap_ready", 64'(wb.req_ready), 64'h2);
    tick();
    check("wrap_we", 64'(wb.rf_we), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_we",    64'(wb.rf_we),     64'h0);
    check("async_clr",   64'(wb.sb_clr),    64'h0);
    check("async_waddr", 64'(wb.rf_waddr),  64'h0);
    check("async_wdata", 64'(wb.rf_wdata),  64'h0);
    check("async_clrrd", 64'(wb.sb_clr_rd), 64'h0);
    check("async_ready", 64'(wb.req_ready), 64'h0);
    rst = 1'b0;
    #1;
    check("rearb_ready", 64'(wb.req_ready), 64'h2);
    tick();
    check("rearb_waddr", 64'(wb.rf_waddr), 64'd9);
    wb.req_valid = 3'b000;
    #1;
    tick();
    // Idle cycle: strobes drop, address holds. ptr=2.
    check("idle_we",    64'(wb.rf_we),    64'h0);
    check("idle_waddr", 64'(wb.rf_waddr), 64'd9);

    // Single requester: unit 2, rd=5.
    set_unit(2, 5'd5, 32'hDEAD_BEEF);
    wb.req_valid = 3'b100;
    #1;
    check("single_ready", 64'(wb.req_ready), 64'h4);
    tick();
    wb.req_valid = 3'b000;
    check("single_we",    64'(wb.rf_we),     64'h1);
    check("single_waddr", 64'(wb.rf_waddr),  64'd5);
    check("single_wdata", 64'(wb.rf_wdata),  64'hDEAD_BEEF);
    check("single_clr",   64'(wb.sb_clr),    64'h1);
    check("single_clrrd", 64'(wb.sb_clr_rd), 64'd5);

    // Contention: ptr=0, expect grants 0,1,2,0,1,2.
    set_unit(0, 5'd1, 32'h11);
    set_unit(1, 5'd2, 32'h22);
    set_unit(2, 5'd3, 32'h33);
    wb.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("cont_ready", 64'(wb.req_ready), 64'(1 << (k % 3)));
      tick();
      check("cont_waddr", 64'(wb.rf_waddr), 64'((k % 3) + 1));
      check("cont_wdata", 64'(wb.rf_wdata), 64'(((k % 3) + 1) * 32'h11));
    end

    // Stall with units 0 and 1 pending; ptr stays 0.
    wb.req_valid = 3'b011;
    wb.wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 64'(wb.req_ready), 64'h0);
      tick();
      check("stall_we", 64'(wb.rf_we), 64'h0);
    end
    wb.wb_stall = 1'b0;
    #1;
    check("unstall_ready", 64'(wb.req_ready), 64'h1);
    tick();
    check("unstall_waddr", 64'(wb.rf_waddr), 64'd1);

    // x0 write from unit 0 (ptr=1, unit 1 idle, unit 2 idle).
    set_unit(0, 5'd0, 32'h1234);
    wb.req_valid = 3'b001;
    #1;
    check("x0_ready", 64'(wb.req_ready), 64'h1);
    tick();
    check("x0_we",    64'(wb.rf_we),    64'h0);
    check("x0_clr",   64'(wb.sb_clr),   64'h0);
    check("x0_wdata", 64'(wb.rf_wdata), 64'h1234);

    // Pointer advanced to 1: unit 1 beats unit 0. Also the bypass case.
    set_unit(1, 5'd7, 32'hA5);
    wb.req_valid = 3'b011;
    #1;
    check("x0_ptr_ready", 64'(wb.req_ready), 64'h2);
`ifdef WB_BYPASS_EN
    check("byp_valid", 64'(wb.byp_valid), 64'h1);
    check("byp_rd",    64'(wb.byp_rd),    64'd7);
    check("byp_data",  64'(wb.byp_data),  64'hA5);
`endif
    tick();
    check("byp_follow_we",    64'(wb.rf_we),    64'h1);
    check("byp_follow_waddr", 64'(wb.rf_waddr), 64'd7);
    check("byp_follow_wdata", 64'(wb.rf_wdata), 64'hA5);
`ifdef WB_BYPASS_EN
    // Unit 0 now wins with rd=0: no bypass strobe.
    wb.req_valid = 3'b001;
    #1;
    check("byp_x0_valid", 64'(wb.byp_valid), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares the single register-file write port among the pipeline's function units (ALU, load unit, multiply/divide). Each unit presents a completed result with a valid/ready handshake. The arbiter grants one per cycle and registers the winning write toward the register file. In the same registered cycle it issues the pending-bit clear for the destination register to the hazard scoreboard. It sits between the execute/memory units and the register file / scoreboard.

## Interface
- `NREQ`, 3, number of requesting function units (2..8)
- `XLEN`, 32, result data width
- `clk` input 1: sole clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `req_valid` input NREQ: bit i = unit i has a result pending
- `req_rd` input NREQ*5: unit i destination register in bits [5i+4:5i]
- `req_data` input NREQ*XLEN: unit i result in bits [XLEN*i+XLEN-1:XLEN*i]
- `req_ready` output NREQ: one-hot grant; transfer when valid&ready
- `wb_stall` input 1: high = no grants this cycle (register-file port busy)
- `rf_we` output 1: register-file write enable
- `rf_waddr` output 5: write address
- `rf_wdata` output XLEN: write data
- `sb_clr` output 1: scoreboard pending-clear strobe
- `sb_clr_rd` output 5: register whose pending bit is cleared
- `byp_valid`, `byp_rd[5]`, `byp_data[XLEN]` output: present only under `WB_BYPASS_EN`

## Operation
- State:
  - round-robin pointer `ptr` (clog2(NREQ) bits)
  - one output register stage holding we/waddr/wdata/clr/clr_rd
- Arbitration is combinational each cycle. Search `req_valid` starting at index `ptr`, wrapping modulo NREQ. The first set bit wins.
- `req_ready` is one-hot on the winner, or all-zero if `wb_stall`=1 or no request is valid. `req_ready` never asserts on an invalid requester.
- On transfer from unit i:
  - `ptr <= (i+1) mod NREQ`
  - the output register loads rd/data from unit i
  - `rf_we` and `sb_clr` are set unless rd==0
- If there is no transfer, `ptr` holds, and `rf_we`/`sb_clr` deassert the next cycle. `rf_waddr`/`rf_wdata`/`sb_clr_rd` hold their last values.
- Writes to x0 are accepted (`req_ready` high) but produce no `rf_we` and no `sb_clr`. The pointer still advances.
- Requesters hold valid/rd/data stable until granted. The arbiter never drops an accepted result.
- Fairness: a continuously valid requester is granted within NREQ cycles of `wb_stall`=0 activity. It waits for at most NREQ-1 other grants.
- Two units targeting the same rd in one cycle are served in pointer order, one per cycle. The arbiter does no reordering beyond that.

## Timing
- Reset (async, immediate) values:
  - `ptr`=0
  - `rf_we`=0, `sb_clr`=0
  - `rf_waddr`=0, `sb_clr_rd`=0, `rf_wdata`=0
  - `req_ready` combinationally 0 while `rst`=1
- Reset mid-operation discards the in-flight output-register write. The requester keeps its valid high and is re-arbitrated after reset.
- Latency: transfer in cycle N → `rf_we`/`sb_clr` high during cycle N+1 (visible after edge N→N+1). `rf_we` and `sb_clr` always assert in the same cycle.
- Throughput: one write per cycle when `wb_stall`=0.
- `wb_stall` acts combinationally on `req_ready` in the same cycle. It does not cancel the already-registered output.
- `req_ready` depends combinationally on `req_valid`, `wb_stall`, `ptr`. It has no dependence on `req_data`.

## Configuration
- `WB_BYPASS_EN` defined:
  - `byp_valid`/`byp_rd`/`byp_data` present
  - they combinationally mirror the winning transfer in the cycle it occurs
  - `byp_valid` = transfer && rd!=0, giving decode one cycle of early forwarding
- `WB_BYPASS_EN` undefined:
  - bypass ports absent
  - behaviour otherwise identical

## Test plan
- Reset: assert `rst` mid-cycle with unit 1 valid → all outputs 0 immediately. After release, the first grant goes to unit 1 (ptr=0, unit 0 idle).
- Single requester: unit 2 valid, rd=5, data=0xDEADBEEF → `req_ready`=3'b100 in cycle N. Next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `sb_clr`=1, `sb_clr_rd`=5.
- Contention: all three units valid continuously (rd=1,2,3) → grants 0,1,2,0,…. `rf_waddr` sequence 1,2,3,1 one cycle later.
- Stall: `wb_stall`=1 for 3 cycles with units 0 and 1 valid → `req_ready`=0, `rf_we`=0 on the following cycles, `ptr` unchanged. Release → unit 0 granted first.
- x0 write: unit 0 rd=0 data=0x1234 → `req_ready`[0]=1, `rf_we`=0, `sb_clr`=0 next cycle, `ptr`→1.
- Bypass (with `WB_BYPASS_EN`): unit 1 rd=7 data=0xA5 → `byp_valid`=1, `byp_rd`=7, `byp_data`=0xA5 in the grant cycle. `rf_we` follows one cycle later.
